// File: rtl/sp_core_pkg.sv
// Shared types and default sizing for the sparse tensor core sequencer.
package sp_core_pkg;

  localparam int DEF_NUM_OCTETS     = 4;
  localparam int DEF_C_DATA_WIDTH   = 128;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_CYC_WIDTH      = 32;

  // Timer must be able to hold TIMEOUT_CYCLES itself.
  localparam int DEF_TMR_W = $clog2(DEF_TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_FETCH  = 3'd2,
    ST_RUN    = 3'd3,
    ST_RESP   = 3'd4
  } sp_seq_state_t;

endpackage

// File: rtl/sp_lane_capture.sv
// One octet lane: result capture register and its done flag.
module sp_lane_capture import sp_core_pkg::*; #(
  parameter int C_DATA_WIDTH = DEF_C_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    wb,
  input  logic [C_DATA_WIDTH-1:0] data,
  output logic [C_DATA_WIDTH-1:0] q,
  output logic                    done,
  output logic                    cap
);

  // Only the first write-back of a run is kept.
  assign cap = en & wb & ~done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q    <= '0;
      done <= 1'b0;
    end else if (clr) begin
      q    <= '0;
      done <= 1'b0;
    end else if (cap) begin
      q    <= data;
      done <= 1'b1;
    end
  end

endmodule

// File: rtl/sp_tensor_core_seq.sv
// Sequencer and result collector for NUM_OCTETS sparse octet engines,
// with completion timeout and launch-to-response latency counter.
module sp_tensor_core_seq import sp_core_pkg::*; #(
  parameter int NUM_OCTETS     = DEF_NUM_OCTETS,
  parameter int C_DATA_WIDTH   = DEF_C_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CYC_WIDTH      = DEF_CYC_WIDTH
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [NUM_OCTETS-1:0]              cmd_mask,
  input  logic                               fetch_done,
  output logic [NUM_OCTETS-1:0]              oct_start,
  output logic [NUM_OCTETS-1:0]              oct_fetch_done,
  input  logic [NUM_OCTETS-1:0]              oct_write_back,
  input  logic [NUM_OCTETS*C_DATA_WIDTH-1:0] oct_result,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [NUM_OCTETS*C_DATA_WIDTH-1:0] res_data,
  output logic [NUM_OCTETS-1:0]              res_mask,
  output logic                               res_err,
  output logic [CYC_WIDTH-1:0]               res_cycles,
  output logic                               busy
);

  localparam int TMR_REQ = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TMR_W   = (TMR_REQ > DEF_TMR_W) ? TMR_REQ : DEF_TMR_W;

  sp_seq_state_t             state, state_d;
  logic [NUM_OCTETS-1:0]     mask_q;
  logic [NUM_OCTETS-1:0]     done;
  logic [NUM_OCTETS-1:0]     cap;
  logic [TMR_W-1:0]          timer;
  logic [CYC_WIDTH-1:0]      cyc;
  logic                      accept;
  logic                      in_run;
  logic                      in_wait;
  logic                      complete;
  logic                      timeout;

  function automatic logic [CYC_WIDTH-1:0] sat_inc(input logic [CYC_WIDTH-1:0] v);
    return (v == '1) ? v : v + CYC_WIDTH'(1);
  endfunction

  assign accept   = cmd_valid && (state == ST_IDLE);
  assign in_run   = (state == ST_RUN);
  assign in_wait  = (state == ST_FETCH) || (state == ST_RUN);
  assign complete = in_run && ((done | cap) == mask_q);
  assign timeout  = in_wait && (timer == TMR_W'(TIMEOUT_CYCLES - 1));

  assign cmd_ready      = (state == ST_IDLE);
  assign busy           = (state != ST_IDLE);
  assign res_valid      = (state == ST_RESP);
  assign res_mask       = done;
  assign res_cycles     = cyc;
  assign oct_fetch_done = ((state == ST_FETCH) && fetch_done) ? mask_q : '0;

  for (genvar i = 0; i < NUM_OCTETS; i++) begin : g_lane
    sp_lane_capture #(.C_DATA_WIDTH(C_DATA_WIDTH)) u_lane (
      .clk  (clk),
      .rstn (rstn),
      .clr  (accept),
      .en   (in_run & mask_q[i]),
      .wb   (oct_write_back[i]),
      .data (oct_result[i*C_DATA_WIDTH +: C_DATA_WIDTH]),
      .q    (res_data[i*C_DATA_WIDTH +: C_DATA_WIDTH]),
      .done (done[i]),
      .cap  (cap[i])
    );
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (cmd_valid) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = (mask_q == '0) ? ST_RESP : ST_FETCH;
      ST_FETCH: begin
        if (timeout)         state_d = ST_RESP;
        else if (fetch_done) state_d = ST_RUN;
      end
      ST_RUN:    if (complete || timeout) state_d = ST_RESP;
      ST_RESP:   if (res_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      mask_q    <= '0;
      oct_start <= '0;
      timer     <= '0;
      cyc       <= '0;
      res_err   <= 1'b0;
    end else begin
      state     <= state_d;
      oct_start <= accept ? cmd_mask : '0;
      if (accept) begin
        mask_q  <= cmd_mask;
        timer   <= '0;
        cyc     <= '0;
        res_err <= 1'b0;
      end else begin
        if (in_wait) timer <= timer + TMR_W'(1);
        // Counts LAUNCH through the last cycle before RESP.
        if ((state == ST_LAUNCH) || in_wait) cyc <= sat_inc(cyc);
        if (timeout && !complete) res_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sp_tensor_core_seq.sv
// Directed bench for sp_tensor_core_seq: default-timeout instance plus a TIMEOUT_CYCLES=8 instance.
module tb_sp_tensor_core_seq;

  localparam int N  = 4;
  localparam int W  = 128;
  localparam int BW = N * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, cmd_valid, cmd_valid_t, fetch_done, res_ready;
  logic [N-1:0]  cmd_mask, oct_write_back;
  logic [BW-1:0] oct_result;

  logic          cmd_ready, res_valid, res_err, busy;
  logic [N-1:0]  oct_start, oct_fetch_done, res_mask;
  logic [BW-1:0] res_data;
  logic [31:0]   res_cycles;

  logic          t_cmd_ready, t_res_valid, t_res_err, t_busy;
  logic [N-1:0]  t_oct_start, t_oct_fetch_done, t_res_mask;
  logic [BW-1:0] t_res_data;
  logic [31:0]   t_res_cycles;

  int errors = 0;
  int checks = 0;

  sp_tensor_core_seq dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mask(cmd_mask),
    .fetch_done(fetch_done), .oct_start(oct_start), .oct_fetch_done(oct_fetch_done),
    .oct_write_back(oct_write_back), .oct_result(oct_result), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_mask(res_mask), .res_err(res_err),
    .res_cycles(res_cycles), .busy(busy)
  );

  sp_tensor_core_seq #(.TIMEOUT_CYCLES(8)) dut_t (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid_t), .cmd_ready(t_cmd_ready), .cmd_mask(cmd_mask),
    .fetch_done(fetch_done), .oct_start(t_oct_start), .oct_fetch_done(t_oct_fetch_done),
    .oct_write_back(oct_write_back), .oct_result(oct_result), .res_valid(t_res_valid),
    .res_ready(res_ready), .res_data(t_res_data), .res_mask(t_res_mask), .res_err(t_res_err),
    .res_cycles(t_res_cycles), .busy(t_busy)
  );

  // Lane i result pattern: every byte is (i+1)*0x11.
  function automatic logic [BW-1:0] exp_data(input logic [N-1:0] m);
    logic [BW-1:0] r;
    logic [7:0]    b;
    r = '0;
    for (int i = 0; i < N; i++) begin
      b = 8'((i + 1) * 17);
      if (m[i]) r[i*W +: W] = {16{b}};
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %0b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (oct_start !== 4'b0) begin errors++; $display("FAIL reset_oct_start got %b want 0000", oct_start); end
    checks++; if ({res_valid, res_err, res_mask} !== 6'b0) begin errors++; $display("FAIL reset_res_flags got %b want 000000", {res_valid, res_err, res_mask}); end
    checks++; if (res_data !== '0 || res_cycles !== 32'd0) begin errors++; $display("FAIL reset_res_data_cycles got %h/%0d want 0/0", res_data, res_cycles); end
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  task automatic test_full_mask();
    cmd_mask = 4'b1111;
    cmd_valid = 1'b1;
    step();                                     // c1 LAUNCH
    cmd_valid = 1'b0;
    checks++; if (oct_start !== 4'b1111) begin errors++; $display("FAIL full_oct_start got %b want 1111", oct_start); end
    checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL full_busy got ready=%0b busy=%0b want 0/1", cmd_ready, busy); end
    step();                                     // c2 FETCH
    checks++; if (oct_start !== 4'b0000) begin errors++; $display("FAIL full_start_pulse got %b want 0000", oct_start); end
    step();                                     // c3
    fetch_done = 1'b1;
    #1;
    checks++; if (oct_fetch_done !== 4'b1111) begin errors++; $display("FAIL full_fetch_done got %b want 1111", oct_fetch_done); end
    step(); fetch_done = 1'b0;                  // c4 RUN
    step();                                     // c5
    step(); oct_write_back = 4'b0001;           // c6
    step(); oct_write_back = 4'b0110;           // c7
    step(); oct_write_back = 4'b0000;           // c8
    step(); oct_write_back = 4'b1000;           // c9
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid got %0b want 0", res_valid); end
    step(); oct_write_back = 4'b0000;           // c10 RESP
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL full_res_valid got %0b want 1", res_valid); end
    checks++; if (res_data !== exp_data(4'b1111)) begin errors++; $display("FAIL full_res_data got %h want %h", res_data, exp_data(4'b1111)); end
    checks++; if (res_mask !== 4'b1111 || res_err !== 1'b0) begin errors++; $display("FAIL full_mask_err got %b/%0b want 1111/0", res_mask, res_err); end
    checks++; if (res_cycles !== 32'd9) begin errors++; $display("FAIL full_res_cycles got %0d want 9", res_cycles); end
    handshake();
    checks++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL full_after_hs got valid=%0b ready=%0b want 0/1", res_valid, cmd_ready); end
  endtask

  task automatic test_sparse_mask();
    fetch_done = 1'b1;                          // ignored while idle
    #1;
    checks++; if (oct_fetch_done !== 4'b0000) begin errors++; $display("FAIL sparse_idle_fetch got %b want 0000", oct_fetch_done); end
    fetch_done = 1'b0;
    cmd_mask = 4'b0101;
    cmd_valid = 1'b1;
    step();                                     // c1 LAUNCH
    cmd_valid = 1'b0;
    checks++; if (oct_start !== 4'b0101) begin errors++; $display("FAIL sparse_oct_start got %b want 0101", oct_start); end
    step();                                     // c2 FETCH, early write-back ignored
    fetch_done = 1'b1; oct_write_back = 4'b0001;
    #1;
    checks++; if (oct_fetch_done !== 4'b0101) begin errors++; $display("FAIL sparse_fetch_done got %b want 0101", oct_fetch_done); end
    step(); fetch_done = 1'b0; oct_write_back = 4'b1010;   // c3 RUN, disabled lanes
    step(); oct_write_back = 4'b1111;           // c4
    checks++; if (res_mask !== 4'b0000) begin errors++; $display("FAIL sparse_ignored_wb got %b want 0000", res_mask); end
    step(); oct_write_back = 4'b0000;           // c5 RESP
    checks++; if (res_valid !== 1'b1 || res_mask !== 4'b0101) begin errors++; $display("FAIL sparse_resp got valid=%0b mask=%b want 1/0101", res_valid, res_mask); end
    checks++; if (res_data !== exp_data(4'b0101)) begin errors++; $display("FAIL sparse_res_data got %h want %h", res_data, exp_data(4'b0101)); end
    checks++; if (res_cycles !== 32'd4) begin errors++; $display("FAIL sparse_res_cycles got %0d want 4", res_cycles); end
    handshake();
  endtask

  task automatic test_zero_mask();
    cmd_mask = 4'b0000;
    cmd_valid = 1'b1;
    step();                                     // c1 LAUNCH
    cmd_valid = 1'b0;
    checks++; if (oct_start !== 4'b0000 || res_valid !== 1'b0) begin errors++; $display("FAIL zero_launch got start=%b valid=%0b want 0000/0", oct_start, res_valid); end
    step();                                     // c2 RESP
    checks++; if (res_valid !== 1'b1 || res_cycles !== 32'd1) begin errors++; $display("FAIL zero_resp got valid=%0b cycles=%0d want 1/1", res_valid, res_cycles); end
    checks++; if (res_data !== '0 || res_mask !== 4'b0000) begin errors++; $display("FAIL zero_data got %h/%b want 0/0000", res_data, res_mask); end
    handshake();
  endtask

  task automatic test_back_to_back();
    cmd_mask = 4'b0001;
    cmd_valid = 1'b1;
    step(); cmd_valid = 1'b0;                   // c1 LAUNCH
    step(); fetch_done = 1'b1;                  // c2 FETCH
    step(); fetch_done = 1'b0; oct_write_back = 4'b0001;   // c3 RUN
    step(); oct_write_back = 4'b0000;           // c4 RESP
    cmd_mask = 4'b1111;
    cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (res_valid !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold%0d got valid=%0b ready=%0b want 1/0", k, res_valid, cmd_ready); end
      checks++; if (res_mask !== 4'b0001 || res_cycles !== 32'd3 || res_data !== exp_data(4'b0001)) begin errors++; $display("FAIL b2b_stable%0d got mask=%b cycles=%0d", k, res_mask, res_cycles); end
      step();
    end
    handshake();                                // edge h
    checks++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_release got valid=%0b ready=%0b want 0/1", res_valid, cmd_ready); end
    step(); cmd_valid = 1'b0;                   // accepted at h+1
    checks++; if (oct_start !== 4'b1111) begin errors++; $display("FAIL b2b_next_start got %b want 1111", oct_start); end
    step(); fetch_done = 1'b1;
    step(); fetch_done = 1'b0; oct_write_back = 4'b1111;
    step(); oct_write_back = 4'b0000;
    checks++; if (res_valid !== 1'b1 || res_mask !== 4'b1111 || res_cycles !== 32'd3) begin errors++; $display("FAIL b2b_second got valid=%0b mask=%b cycles=%0d want 1/1111/3", res_valid, res_mask, res_cycles); end
    handshake();
  endtask

  task automatic test_timeout();
    cmd_mask = 4'b1111;
    cmd_valid_t = 1'b1;
    step(); cmd_valid_t = 1'b0;                 // c1 LAUNCH
    step(); fetch_done = 1'b1;                  // c2 FETCH (1st timed cycle)
    step(); fetch_done = 1'b0; oct_write_back = 4'b1011;   // c3 RUN
    step(); oct_write_back = 4'b0000;           // c4
    repeat (5) step();                          // c9 (8th timed cycle)
    checks++; if (t_res_valid !== 1'b0) begin errors++; $display("FAIL tmo_early got %0b want 0", t_res_valid); end
    step();                                     // c10 RESP
    checks++; if (t_res_valid !== 1'b1 || t_res_err !== 1'b1) begin errors++; $display("FAIL tmo_resp got valid=%0b err=%0b want 1/1", t_res_valid, t_res_err); end
    checks++; if (t_res_mask !== 4'b1011 || t_res_data !== exp_data(4'b1011)) begin errors++; $display("FAIL tmo_data got mask=%b data=%h want 1011", t_res_mask, t_res_data); end
    checks++; if (t_res_cycles !== 32'd9) begin errors++; $display("FAIL tmo_cycles got %0d want 9", t_res_cycles); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL tmo_main_idle got %0b want 1", cmd_ready); end
    handshake();
    // completion on the timeout edge
    cmd_valid_t = 1'b1;
    step(); cmd_valid_t = 1'b0;                 // c1
    step(); fetch_done = 1'b1;                  // c2
    step(); fetch_done = 1'b0;                  // c3
    repeat (6) step();                          // c9
    oct_write_back = 4'b1111;
    step(); oct_write_back = 4'b0000;           // c10
    checks++; if (t_res_valid !== 1'b1 || t_res_err !== 1'b0 || t_res_mask !== 4'b1111) begin errors++; $display("FAIL tmo_tie got valid=%0b err=%0b mask=%b want 1/0/1111", t_res_valid, t_res_err, t_res_mask); end
    handshake();
  endtask

  task automatic test_reset_midrun();
    cmd_mask = 4'b1111;
    cmd_valid = 1'b1;
    step(); cmd_valid = 1'b0;
    step(); fetch_done = 1'b1;
    step(); fetch_done = 1'b0; oct_write_back = 4'b0011;
    step(); oct_write_back = 4'b0000;
    checks++; if (res_mask !== 4'b0011 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre got mask=%b busy=%0b want 0011/1", res_mask, busy); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl got ready=%0b busy=%0b valid=%0b", cmd_ready, busy, res_valid); end
    checks++; if (res_mask !== 4'b0 || res_data !== '0 || res_cycles !== 32'd0) begin errors++; $display("FAIL mid_rst_data got mask=%b cycles=%0d", res_mask, res_cycles); end
    @(negedge clk);
    rstn = 1'b1;
    step();
    cmd_mask = 4'b0100;
    cmd_valid = 1'b1;
    step(); cmd_valid = 1'b0;
    checks++; if (oct_start !== 4'b0100) begin errors++; $display("FAIL mid_restart_start got %b want 0100", oct_start); end
    step(); fetch_done = 1'b1;
    step(); fetch_done = 1'b0; oct_write_back = 4'b0100;
    step(); oct_write_back = 4'b0000;
    checks++; if (res_valid !== 1'b1 || res_mask !== 4'b0100 || res_err !== 1'b0 || res_cycles !== 32'd3) begin errors++; $display("FAIL mid_restart_resp got valid=%0b mask=%b err=%0b cycles=%0d", res_valid, res_mask, res_err, res_cycles); end
    checks++; if (res_data !== exp_data(4'b0100)) begin errors++; $display("FAIL mid_restart_data got %h want %h", res_data, exp_data(4'b0100)); end
    handshake();
  endtask

  initial begin
    rstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_valid_t = 1'b0;
    fetch_done = 1'b0;
    res_ready = 1'b0;
    cmd_mask = '0;
    oct_write_back = '0;
    oct_result = exp_data(4'b1111);
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_zero_mask();
    test_back_to_back();
    test_timeout();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
